lzc_norm_pipe: RTL and testbench

Pipelined leading-zero / redundant-sign-bit counter with an integrated normalising left shift.
- Successor to the combinational LZC used in the reciprocal and fixed-point normalisation paths.
- Generalised to any WIDTH ≥ 2, including non-powers-of-2 (internal padding).
- Adds a per-transaction signed mode, a valid/ready handshake with full backpressure, and a sideband tag.
- Sits between the ray-step datapath and the reciprocal LUT/Newton stage; sustains one result per clock.

---
 rtl/lzc_pkg.sv | 17 +
 rtl/lzc_tree.sv | 61 ++++++
 rtl/lzc_norm_pipe.sv | 97 +++++++++
 tb/tb_lzc_norm_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared types and width helpers for the leading-zero / redundant-sign counters.
package lzc_pkg;

    typedef enum logic {
        LZC_UNSIGNED = 1'b0,
        LZC_SIGNED   = 1'b1
    } lzc_mode_t;

    function automatic int lzc_cw(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int lzc_padw(input int width);
        return 1 << $clog2(width);
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational balanced-tree leading-zero / redundant-sign-bit counter.
// Input is padded on the LSB side to a power of two so the count never exceeds WIDTH.
module lzc_tree
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 24,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  lzc_mode_t        mode,
    output logic [CW-1:0]    count,
    output logic             allzero
);

    localparam int PADW = lzc_padw(WIDTH);
    localparam int LOG  = $clog2(PADW);
    localparam logic [LOG:0] PADW_V = PADW[LOG:0];

    logic [WIDTH-1:0] w_vec;
    logic [PADW-1:0]  w_pad;
    logic             w_z [LOG+1][PADW];
    logic [LOG-1:0]   w_c [LOG+1][PADW];
    logic [LOG:0]     w_root;

    always_comb begin
        // Signed mode: mark bits that differ from the MSB, drop the MSB itself and
        // append a terminating one so an all-sign operand yields WIDTH-1.
        w_vec = data;
        if (mode == LZC_SIGNED) begin
            w_vec = {data[WIDTH-2:0] ^ {(WIDTH-1){data[WIDTH-1]}}, 1'b1};
        end
        w_pad = '1;
        w_pad[PADW-1 -: WIDTH] = w_vec;

        for (int unsigned l = 0; l <= LOG; l++) begin
            for (int unsigned i = 0; i < PADW; i++) begin
                w_z[l][i] = 1'b0;
                w_c[l][i] = '0;
            end
        end
        for (int unsigned i = 0; i < PADW; i++) begin
            w_z[0][i] = ~w_pad[i];
        end
        for (int unsigned l = 1; l <= LOG; l++) begin
            for (int unsigned i = 0; i < (PADW >> l); i++) begin
                w_z[l][i] = w_z[l-1][2*i+1] & w_z[l-1][2*i];
                if (w_z[l-1][2*i+1]) begin
                    w_c[l][i]      = w_c[l-1][2*i];
                    w_c[l][i][l-1] = 1'b1;
                end else begin
                    w_c[l][i] = w_c[l-1][2*i+1];
                end
            end
        end

        w_root  = w_z[LOG][0] ? PADW_V : {1'b0, w_c[LOG][0]};
        count   = CW'(w_root);
        allzero = ~|data;
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined LZC / redundant-sign counter with normalising left shift,
// valid/ready handshake with full backpressure and a sideband tag.
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 24,
    parameter  int TAG_W = 4,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic             w_adv1;
    logic             w_adv2;
    logic [CW-1:0]    w_count;
    logic             w_zero;
    lzc_mode_t        w_mode;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [CW-1:0]    r_s1_count;
    logic             r_s1_zero;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_norm;
    logic [CW-1:0]    r_s2_count;
    logic             r_s2_zero;
    logic [TAG_W-1:0] r_s2_tag;

    assign w_mode = lzc_mode_t'(in_signed);
    assign w_adv2 = ~r_s2_valid | out_ready;
    assign w_adv1 = ~r_s1_valid | w_adv2;

    lzc_tree #(.WIDTH(WIDTH)) u_tree (
        .data    (in_data),
        .mode    (w_mode),
        .count   (w_count),
        .allzero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_count <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data  <= in_data;
                r_s1_count <= w_count;
                r_s1_zero  <= w_zero;
                r_s1_tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_norm  <= '0;
            r_s2_count <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_norm  <= r_s1_data << r_s1_count;
                r_s2_count <= r_s1_count;
                r_s2_zero  <= r_s1_zero;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    assign in_ready  = w_adv1;
    assign out_valid = r_s2_valid;
    assign out_count = r_s2_count;
    assign out_norm  = r_s2_norm;
    assign out_zero  = r_s2_zero;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: directed scenarios on a WIDTH=24 lane plus a scoreboarded
// random stream driven into lanes of WIDTH 24, 2, 5 and 32 in parallel.
module tb_lzc_norm_pipe;

    localparam int NL = 4;

    typedef struct packed {
        logic [5:0]  cnt;
        logic [31:0] norm;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    function automatic int lane_w(input int k);
        case (k)
            0:       return 24;
            1:       return 2;
            2:       return 5;
            default: return 32;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data [NL];

    logic        o_irdy  [NL];
    logic        o_valid [NL];
    logic [5:0]  o_cnt   [NL];
    logic [31:0] o_norm  [NL];
    logic        o_zero  [NL];
    logic [3:0]  o_tag   [NL];

    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    exp_t q [NL][$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam int W = lane_w(k);
        localparam int C = $clog2(W + 1);
        logic [C-1:0] w_cnt;
        logic [W-1:0] w_norm;
        lzc_norm_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (o_irdy[k]),
            .in_data   (in_data[k][W-1:0]),
            .in_signed (in_signed),
            .in_tag    (in_tag),
            .out_valid (o_valid[k]),
            .out_ready (out_ready),
            .out_count (w_cnt),
            .out_norm  (w_norm),
            .out_zero  (o_zero[k]),
            .out_tag   (o_tag[k])
        );
        assign o_cnt[k]  = 6'(w_cnt);
        assign o_norm[k] = 32'(w_norm);
    end

    // Behavioural reference: bit-by-bit scan from the MSB.
    function automatic exp_t model(input int w, input logic [31:0] d_in, input logic s,
                                   input logic [3:0] t);
        exp_t        e;
        logic [31:0] mask;
        logic [31:0] d;
        logic        msb;
        int          n;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        d    = d_in & mask;
        msb  = d[w-1];
        n    = 0;
        if (!s) begin
            for (int i = w - 1; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
        end else begin
            for (int i = w - 1; i >= 0; i--) begin
                if (d[i] != msb) break;
                n++;
            end
            n = n - 1;
        end
        e.cnt  = 6'(n);
        e.norm = (d << n) & mask;
        e.zero = (d == 32'd0);
        e.tag  = t;
        return e;
    endfunction

    // Transfers are evaluated mid-cycle; they take effect at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int k = 0; k < NL; k++) q[k].delete();
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (o_valid[k] && out_ready) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected lane%0d: got tag=%h with no item outstanding, want no output",
                                 k, o_tag[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (o_cnt[k] !== e.cnt || o_norm[k] !== e.norm ||
                            o_zero[k] !== e.zero || o_tag[k] !== e.tag) begin
                            errors++;
                            $display("FAIL sb_lane%0d: got cnt=%0d norm=%h zero=%b tag=%h, want cnt=%0d norm=%h zero=%b tag=%h",
                                     k, o_cnt[k], o_norm[k], o_zero[k], o_tag[k],
                                     e.cnt, e.norm, e.zero, e.tag);
                        end
                    end
                end
                if (in_valid && o_irdy[k]) begin
                    q[k].push_back(model(lane_w(k), in_data[k], in_signed, in_tag));
                    if (k == 0) n_acc++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic [3:0] t);
        in_valid  = v;
        in_signed = s;
        in_tag    = t;
        for (int k = 0; k < NL; k++) in_data[k] = d;
    endtask

    task automatic drain();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 6'd0 || o_norm[0] !== 32'd0 ||
            o_zero[0] !== 1'b0 || o_tag[0] !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d norm=%h z=%b tag=%h, want all zero",
                     o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0]);
        end
        checks++;
        if (o_irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", o_irdy[0]);
        end
    endtask

    task automatic test_unsigned_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h000001, 1'b0, 4'd3);
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (o_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid got %b want 0", o_valid[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_cnt[0] !== 6'd23 || o_norm[0] !== 32'h800000 ||
            o_zero[0] !== 1'b0 || o_tag[0] !== 4'd3) begin
            errors++;
            $display("FAIL unsigned_one: got v=%b cnt=%0d norm=%h z=%b tag=%h, want v=1 cnt=23 norm=800000 z=0 tag=3",
                     o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 32'h00F000, 1'b0, 4'd5);
        tick();
        drive(1'b1, 32'h000000, 1'b0, 4'd6);
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (o_valid[0] !== 1'b1 || o_cnt[0] !== 6'd8 || o_norm[0] !== 32'hF00000 ||
            o_zero[0] !== 1'b0 || o_tag[0] !== 4'd5) begin
            errors++;
            $display("FAIL b2b_first: got v=%b cnt=%0d norm=%h z=%b tag=%h, want v=1 cnt=8 norm=f00000 z=0 tag=5",
                     o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_cnt[0] !== 6'd24 || o_norm[0] !== 32'd0 ||
            o_zero[0] !== 1'b1 || o_tag[0] !== 4'd6) begin
            errors++;
            $display("FAIL b2b_zero: got v=%b cnt=%0d norm=%h z=%b tag=%h, want v=1 cnt=24 norm=0 z=1 tag=6",
                     o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0]);
        end
        drain();
    endtask

    task automatic test_signed();
        logic [31:0] d  [4] = '{32'hFFF000, 32'h3FFFFF, 32'h000000, 32'hFFFFFF};
        logic [5:0]  ec [4] = '{6'd11, 6'd1, 6'd23, 6'd23};
        logic [31:0] en [4] = '{32'h800000, 32'h7FFFFE, 32'h000000, 32'h800000};
        logic        ez [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, d[i], 1'b1, 4'(i + 8));
            else       drive(1'b0, 32'd0, 1'b0, 4'd0);
            tick();
            if (i >= 1) begin
                checks++;
                if (o_valid[0] !== 1'b1 || o_cnt[0] !== ec[i-1] || o_norm[0] !== en[i-1] ||
                    o_zero[0] !== ez[i-1] || o_tag[0] !== 4'(i + 7)) begin
                    errors++;
                    $display("FAIL signed_%0d: got v=%b cnt=%0d norm=%h z=%b tag=%h, want v=1 cnt=%0d norm=%h z=%b tag=%h",
                             i - 1, o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0],
                             ec[i-1], en[i-1], ez[i-1], 4'(i + 7));
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h000001, 1'b0, 4'd1);
        tick();
        checks++;
        if (o_irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_second: got %b want 1", o_irdy[0]);
        end
        drive(1'b1, 32'h00F000, 1'b0, 4'd2);
        tick();
        drive(1'b1, 32'h000000, 1'b0, 4'd3);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (o_irdy[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_full c%0d: got %b want 0", j, o_irdy[0]);
            end
            checks++;
            if (o_valid[0] !== 1'b1 || o_tag[0] !== 4'd1 || o_cnt[0] !== 6'd23 ||
                o_norm[0] !== 32'h800000 || o_zero[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c%0d: got v=%b tag=%h cnt=%0d norm=%h z=%b, want v=1 tag=1 cnt=23 norm=800000 z=0",
                         j, o_valid[0], o_tag[0], o_cnt[0], o_norm[0], o_zero[0]);
            end
            for (int k = 0; k < NL; k++) in_data[k] = $urandom;
            in_signed = 1'($urandom);
            tick();
        end
        drive(1'b1, 32'h000000, 1'b0, 4'd3);
        out_ready = 1'b1;
        #1;
        checks++;
        if (o_irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", o_irdy[0]);
        end
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (o_valid[0] !== 1'b1 || o_tag[0] !== 4'd2 || o_cnt[0] !== 6'd8) begin
            errors++;
            $display("FAIL bp_order2: got v=%b tag=%h cnt=%0d, want v=1 tag=2 cnt=8",
                     o_valid[0], o_tag[0], o_cnt[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_tag[0] !== 4'd3 || o_cnt[0] !== 6'd24 || o_zero[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_order3: got v=%b tag=%h cnt=%0d z=%b, want v=1 tag=3 cnt=24 z=1",
                     o_valid[0], o_tag[0], o_cnt[0], o_zero[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid got %b want 0", o_valid[0]);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 32'h000100, 1'b0, 4'hA);
        tick();
        drive(1'b1, 32'h0000F0, 1'b1, 4'hB);
        tick();
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 6'd0 || o_norm[0] !== 32'd0 ||
            o_zero[0] !== 1'b0 || o_tag[0] !== 4'd0 || o_irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset: got v=%b cnt=%0d norm=%h z=%b tag=%h rdy=%b, want v=0 zeros rdy=1",
                     o_valid[0], o_cnt[0], o_norm[0], o_zero[0], o_tag[0], o_irdy[0]);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (o_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale c%0d: out_valid got %b want 0", j, o_valid[0]);
            end
        end
    endtask

    task automatic test_random();
        int          cyc;
        int unsigned sel;
        int unsigned sh;
        logic [31:0] d;
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 4'd0);
        repeat (2) tick();
        reset = 1'b0;
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            sel = $urandom_range(0, 7);
            sh  = $urandom_range(0, 31);
            case (sel)
                0:       d = 32'd0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'd1 << sh;
                3:       d = ~(32'd1 << sh);
                4:       d = $urandom >> sh;
                default: d = $urandom;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_signed = 1'($urandom);
            in_tag    = 4'($urandom);
            for (int k = 0; k < NL; k++) in_data[k] = d;
            tick();
            cyc++;
        end
        checks++;
        if (n_acc < 10000) begin
            errors++;
            $display("FAIL rand_accept_budget: got %0d accepted want 10000", n_acc);
        end
        drain();
        for (int k = 0; k < NL; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL rand_drain lane%0d: got %0d outstanding want 0", k, q[k].size());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NL; k++) in_data[k] = '0;
        test_reset();
        test_unsigned_single();
        test_back_to_back();
        test_signed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
